// File: rtl/icache_sa_pkg.sv
// Shared constants, state encoding and address-split width helpers for icache_sa.

package icache_sa_pkg;

   localparam logic        TRUE  = 1'b1;
   localparam logic        FALSE = 1'b0;
   localparam logic [31:0] ZERO  = 32'h0;

   typedef enum logic {
      StIdle   = 1'b0,
      StRefill = 1'b1
   } state_e;

   function automatic int unsigned off_w(input int unsigned block_words);
      return $clog2(block_words);
   endfunction

   function automatic int unsigned idx_w(input int unsigned sets);
      return $clog2(sets);
   endfunction

   // Remaining pc bits above offset, index and the byte-in-word field.
   function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned sets,
                                         input int unsigned block_words);
      return addr_w - off_w(block_words) - idx_w(sets) - 2;
   endfunction

endpackage

// File: rtl/icache_way.sv
// One way of icache_sa: per-set valid bit, tag and data line, with lookup and write ports.

module icache_way
   import icache_sa_pkg::*;
#(
   parameter  int unsigned SETS        = 16,
   parameter  int unsigned BLOCK_WORDS = 4,
   parameter  int unsigned TAG_W       = 9,
   localparam int unsigned IDX_W       = idx_w(SETS),
   localparam int unsigned OFF_W       = off_w(BLOCK_WORDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] lk_idx,
   input  logic [TAG_W-1:0] lk_tag,
   input  logic [OFF_W-1:0] lk_off,
   output logic             hit,
   output logic [31:0]      word,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [OFF_W-1:0] wr_off,
   input  logic [31:0]      wr_data,
   input  logic             wr_word,
   input  logic             wr_tag_en,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic             set_valid,
   input  logic             clr_valid,
   input  logic             clr_all
);

   logic [SETS-1:0]  valid_q;
   logic [TAG_W-1:0] tag_q  [SETS];
   logic [31:0]      data_q [SETS][BLOCK_WORDS];

   // Global clear wins so a flush coinciding with the last refill word leaves the line invalid.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= '0;
      end else if (clr_all) begin
         valid_q <= '0;
      end else if (clr_valid) begin
         valid_q[wr_idx] <= FALSE;
      end else if (set_valid) begin
         valid_q[wr_idx] <= TRUE;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_word) begin
         data_q[wr_idx][wr_off] <= wr_data;
      end
      if (wr_tag_en) begin
         tag_q[wr_idx] <= wr_tag;
      end
   end

   assign hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign word = data_q[lk_idx][lk_off];

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache with round-robin replacement and sequential line refill.
// Define ICACHE_FORWARD_EN to forward the requested word from mc_data during refill.

module icache_sa
   import icache_sa_pkg::*;
#(
   parameter int unsigned ADDR_W      = 17,
   parameter int unsigned WAYS        = 2,
   parameter int unsigned SETS        = 16,
   parameter int unsigned BLOCK_WORDS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              flush,
   input  logic              fet_req,
   input  logic [31:0]       fet_pc,
   output logic              fet_valid,
   output logic [31:0]       fet_instr,
   output logic              mc_req,
   output logic [ADDR_W-1:0] mc_addr,
   input  logic              mc_valid,
   input  logic [31:0]       mc_data
);

   localparam int unsigned OFF_W = off_w(BLOCK_WORDS);
   localparam int unsigned IDX_W = idx_w(SETS);
   localparam int unsigned TAG_W = tag_w(ADDR_W, SETS, BLOCK_WORDS);
   localparam int unsigned VP_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

   logic [OFF_W-1:0]  pc_off;
   logic [IDX_W-1:0]  pc_idx;
   logic [TAG_W-1:0]  pc_tag;
   logic [ADDR_W-1:0] pc_base;
   logic              unused_pc;

   assign pc_off    = fet_pc[OFF_W+1:2];
   assign pc_idx    = fet_pc[OFF_W+IDX_W+1:OFF_W+2];
   assign pc_tag    = fet_pc[ADDR_W-1:OFF_W+IDX_W+2];
   assign pc_base   = {fet_pc[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
   assign unused_pc = ^{fet_pc[31:ADDR_W], fet_pc[1:0]};

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  set_q, set_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [VP_W-1:0]   way_q, way_d;
   logic [OFF_W-1:0]  cnt_q, cnt_d;
   logic              mc_req_q, mc_req_d;
   logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
   logic              poison_q, poison_d;
   logic [VP_W-1:0]   vptr_q [SETS];

   logic [WAYS-1:0] way_hit;
   logic [31:0]     way_word [WAYS];
   logic            raw_hit;
   logic            fwd;
   logic            start;
   logic            fill;
   logic            last;
   logic [IDX_W-1:0] wr_idx;

   assign raw_hit = |way_hit;
   assign start   = rdy && (state_q == StIdle) && fet_req && !raw_hit;
   assign fill    = rdy && (state_q == StRefill) && mc_valid;
   assign last    = fill && (cnt_q == OFF_W'(BLOCK_WORDS - 1));
   assign wr_idx  = (state_q == StIdle) ? pc_idx : set_q;

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      logic sel;
      logic start_sel;

      assign sel       = (way_q == VP_W'(w));
      assign start_sel = (vptr_q[pc_idx] == VP_W'(w));

      icache_way #(
         .SETS        (SETS),
         .BLOCK_WORDS (BLOCK_WORDS),
         .TAG_W       (TAG_W)
      ) u_way (
         .clk       (clk),
         .rst       (rst),
         .lk_idx    (pc_idx),
         .lk_tag    (pc_tag),
         .lk_off    (pc_off),
         .hit       (way_hit[w]),
         .word      (way_word[w]),
         .wr_idx    (wr_idx),
         .wr_off    (cnt_q),
         .wr_data   (mc_data),
         .wr_word   (fill && sel),
         .wr_tag_en (last && sel),
         .wr_tag    (tag_q),
         .set_valid (last && sel && !poison_q && !flush),
         .clr_valid (start && start_sel),
         .clr_all   (rdy && flush)
      );
   end

`ifdef ICACHE_FORWARD_EN
   assign fwd = (state_q == StRefill) && mc_valid && !poison_q && (pc_tag == tag_q) &&
                (pc_idx == set_q) && (pc_off == cnt_q);
`else
   assign fwd = FALSE;
`endif

   assign fet_valid = fet_req && !flush && (raw_hit || fwd);

   always_comb begin
      fet_instr = ZERO;
      if (fet_req && !flush) begin
         for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) begin
               fet_instr = fet_instr | way_word[w];
            end
         end
         if (fwd) begin
            fet_instr = mc_data;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      set_d     = set_q;
      tag_d     = tag_q;
      way_d     = way_q;
      cnt_d     = cnt_q;
      mc_req_d  = mc_req_q;
      mc_addr_d = mc_addr_q;
      poison_d  = poison_q;
      unique case (state_q)
         StIdle: begin
            if (fet_req && !raw_hit) begin
               state_d   = StRefill;
               set_d     = pc_idx;
               tag_d     = pc_tag;
               way_d     = vptr_q[pc_idx];
               cnt_d     = '0;
               mc_req_d  = TRUE;
               mc_addr_d = pc_base;
            end
         end
         StRefill: begin
            if (flush) begin
               poison_d = TRUE;
            end
            if (mc_valid) begin
               if (cnt_q != OFF_W'(BLOCK_WORDS - 1)) begin
                  cnt_d     = cnt_q + OFF_W'(1);
                  mc_addr_d = mc_addr_q + ADDR_W'(4);
               end else begin
                  state_d  = StIdle;
                  mc_req_d = FALSE;
                  poison_d = FALSE;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         set_q     <= '0;
         tag_q     <= '0;
         way_q     <= '0;
         cnt_q     <= '0;
         mc_req_q  <= FALSE;
         mc_addr_q <= '0;
         poison_q  <= FALSE;
         for (int s = 0; s < SETS; s++) begin
            vptr_q[s] <= '0;
         end
      end else if (rdy) begin
         state_q   <= state_d;
         set_q     <= set_d;
         tag_q     <= tag_d;
         way_q     <= way_d;
         cnt_q     <= cnt_d;
         mc_req_q  <= mc_req_d;
         mc_addr_q <= mc_addr_d;
         poison_q  <= poison_d;
         if (last) begin
            vptr_q[set_q] <= (WAYS > 1) ? way_q + VP_W'(1) : '0;
         end
      end
   end

   assign mc_req  = mc_req_q;
   assign mc_addr = mc_addr_q;

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa with default parameters (17-bit address, 2 ways, 16 sets, 4 words).

module tb_icache_sa;

`ifdef ICACHE_FORWARD_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        flush;
   logic        fet_req;
   logic [31:0] fet_pc;
   logic        fet_valid;
   logic [31:0] fet_instr;
   logic        mc_req;
   logic [16:0] mc_addr;
   logic        mc_valid;
   logic [31:0] mc_data;

   int n_eval = 0;
   int n_fail = 0;

   icache_sa dut (
      .clk       (clk),
      .rst       (rst),
      .rdy       (rdy),
      .flush     (flush),
      .fet_req   (fet_req),
      .fet_pc    (fet_pc),
      .fet_valid (fet_valid),
      .fet_instr (fet_instr),
      .mc_req    (mc_req),
      .mc_addr   (mc_addr),
      .mc_valid  (mc_valid),
      .mc_data   (mc_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_eval++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expect an outstanding read at addr, then return one data word for it.
   task automatic word(input string tag, input logic [31:0] addr, input logic [31:0] d);
      chk({tag, " mc_req"}, {31'b0, mc_req}, 32'd1);
      chk({tag, " mc_addr"}, {15'b0, mc_addr}, addr);
      mc_valid = 1'b1;
      mc_data  = d;
      step();
      mc_valid = 1'b0;
   endtask

   task automatic hit(input string tag, input logic [31:0] pc, input logic [31:0] d);
      fet_pc = pc;
      #1;
      chk({tag, " valid"}, {31'b0, fet_valid}, 32'd1);
      chk({tag, " instr"}, fet_instr, d);
   endtask

   task automatic miss(input string tag, input logic [31:0] pc);
      fet_pc = pc;
      #1;
      chk({tag, " valid"}, {31'b0, fet_valid}, 32'd0);
      chk({tag, " instr"}, fet_instr, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; rdy = 1'b1; flush = 1'b0; fet_req = 1'b0; fet_pc = 32'h0;
      mc_valid = 1'b0; mc_data = 32'h0;
      step();
      step();
      rst = 1'b1;
      #1;
      chk("reset fet_valid", {31'b0, fet_valid}, 32'd0);
      chk("reset mc_req", {31'b0, mc_req}, 32'd0);
      chk("reset mc_addr", {15'b0, mc_addr}, 32'h0);

      // Cold miss at 0x100 into way 0 of set 0.
      fet_req = 1'b1;
      miss("cold 100", 32'h100);
      chk("cold idle mc_req", {31'b0, mc_req}, 32'd0);
      step();
      word("cold w0", 32'h100, 32'hA000_0000);
      word("cold w1", 32'h104, 32'hA000_0001);
      word("cold w2", 32'h108, 32'hA000_0002);
      word("cold w3", 32'h10C, 32'hA000_0003);
      chk("cold done mc_req", {31'b0, mc_req}, 32'd0);
      hit("cold hit 100", 32'h100, 32'hA000_0000);
      hit("cold hit 10c", 32'h10C, 32'hA000_0003);
      step();
      chk("cold no refill", {31'b0, mc_req}, 32'd0);

      // Conflict: 0x1100 fills way 1, 0x2100 evicts way 0 (0x100).
      miss("conf 1100", 32'h1100);
      step();
      word("conf1 w0", 32'h1100, 32'hB000_0000);
      word("conf1 w1", 32'h1104, 32'hB000_0001);
      word("conf1 w2", 32'h1108, 32'hB000_0002);
      word("conf1 w3", 32'h110C, 32'hB000_0003);
      hit("conf hit 1100", 32'h1100, 32'hB000_0000);
      hit("conf keep 100", 32'h104, 32'hA000_0001);
      miss("conf 2100", 32'h2100);
      step();
      word("conf2 w0", 32'h2100, 32'hC000_0000);
      word("conf2 w1", 32'h2104, 32'hC000_0001);
      word("conf2 w2", 32'h2108, 32'hC000_0002);
      word("conf2 w3", 32'h210C, 32'hC000_0003);
      hit("conf hit 2100", 32'h2100, 32'hC000_0000);
      miss("conf evicted 100", 32'h100);
      hit("conf hit 1104", 32'h1104, 32'hB000_0001);

      // Flush after two words of a refill of 0x100 (victim way 1).
      miss("fl 100", 32'h100);
      step();
      word("fl w0", 32'h100, 32'hD000_0000);
      word("fl w1", 32'h104, 32'hD000_0001);
      hit("fl other line hit", 32'h2104, 32'hC000_0001);
      flush = 1'b1;
      miss("fl forced", 32'h2100);
      step();
      flush = 1'b0;
      miss("fl cleared", 32'h2100);
      word("fl w2", 32'h108, 32'hD000_0002);
      word("fl w3", 32'h10C, 32'hD000_0003);
      chk("fl done mc_req", {31'b0, mc_req}, 32'd0);
      miss("fl poisoned 100", 32'h100);
      step();

      // Refetch of 0x100 with rdy low for three cycles after the first word.
      word("rdy w0", 32'h100, 32'hE000_0000);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rdy hold mc_addr", {15'b0, mc_addr}, 32'h104);
         chk("rdy hold mc_req", {31'b0, mc_req}, 32'd1);
      end
      rdy = 1'b1;
      word("rdy w1", 32'h104, 32'hE000_0001);
      word("rdy w2", 32'h108, 32'hE000_0002);
      word("rdy w3", 32'h10C, 32'hE000_0003);
      hit("rdy hit 100", 32'h100, 32'hE000_0000);
      hit("rdy hit 108", 32'h108, 32'hE000_0002);

      // Reset during the refill of 0x300, then 0x100 must refetch.
      miss("rst 300", 32'h300);
      step();
      word("rst w0", 32'h300, 32'h3000_0000);
      word("rst w1", 32'h304, 32'h3000_0001);
      rst = 1'b0;
      step();
      rst = 1'b1;
      miss("rst 100 miss", 32'h100);
      chk("rst mc_req", {31'b0, mc_req}, 32'd0);
      chk("rst mc_addr", {15'b0, mc_addr}, 32'h0);
      step();
      word("rst2 w0", 32'h100, 32'hF000_0000);
      word("rst2 w1", 32'h104, 32'hF000_0001);
      word("rst2 w2", 32'h108, 32'hF000_0002);
      word("rst2 w3", 32'h10C, 32'hF000_0003);
      hit("rst2 hit 104", 32'h104, 32'hF000_0001);

      // Miss at 0x408: forward only when enabled, on the third word.
      miss("fwd 408", 32'h408);
      step();
      word("fwd w0", 32'h400, 32'h4000_0000);
      word("fwd w1", 32'h404, 32'h4000_0001);
      chk("fwd w2 mc_addr", {15'b0, mc_addr}, 32'h408);
      mc_valid = 1'b1;
      mc_data  = 32'h4000_0002;
      #1;
      chk("fwd w2 valid", {31'b0, fet_valid}, {31'b0, FWD});
      chk("fwd w2 instr", fet_instr, FWD ? 32'h4000_0002 : 32'h0);
      step();
      mc_valid = 1'b0;
      #1;
      chk("fwd gap valid", {31'b0, fet_valid}, 32'd0);
      word("fwd w3", 32'h40C, 32'h4000_0003);
      hit("fwd hit 408", 32'h408, 32'h4000_0002);

      // Flush coinciding with the final word leaves the line invalid.
      miss("flf 500", 32'h500);
      step();
      word("flf w0", 32'h500, 32'h5000_0000);
      word("flf w1", 32'h504, 32'h5000_0001);
      word("flf w2", 32'h508, 32'h5000_0002);
      chk("flf w3 mc_addr", {15'b0, mc_addr}, 32'h50C);
      mc_valid = 1'b1;
      mc_data  = 32'h5000_0003;
      flush    = 1'b1;
      step();
      mc_valid = 1'b0;
      flush    = 1'b0;
      fet_req  = 1'b0;
      #1;
      chk("flf mc_req", {31'b0, mc_req}, 32'd0);
      fet_req = 1'b1;
      miss("flf invalid 500", 32'h500);

      $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
      $finish;
   end

endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
- Parametrised set-associative instruction cache between the instruction fetcher and the memory controller.
- Next generation of the direct-mapped fetch cache: configurable ways, sets and block size; per-set round-robin replacement; whole-cache invalidate (fence.i / program reload).
- Hit returns the instruction combinationally in the same cycle. A miss runs a sequential multi-word refill over the memory-controller word port.

Parameters:
- ADDR_W, 17, memory address width; pc bits above ADDR_W-1 are ignored.
- WAYS, 2, associativity; legal values 1, 2, 4.
- SETS, 16, sets per way; power of two, at least 2.
- BLOCK_WORDS, 4, 32-bit words per line; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- rdy  in  1  global ready; low = hold all state
- flush  in  1  invalidate all lines (one-cycle pulse)
- fet_req  in  1  fetcher requests the instruction at fet_pc
- fet_pc  in  32  byte address; bits [1:0] ignored
- fet_valid  out  1  fet_instr is valid for the current fet_pc
- fet_instr  out  32  instruction word
- mc_req  out  1  memory read request, held for the whole refill
- mc_addr  out  ADDR_W  word-aligned read address
- mc_valid  in  1  mc_data carries the word for mc_addr
- mc_data  in  32  read data

Behaviour:
- Address split:
  - OFF = log2(BLOCK_WORDS) word-offset bits at pc[OFF+1:2].
  - IDX = log2(SETS) index bits directly above the offset.
  - Tag = pc[ADDR_W-1 : OFF+IDX+2].
- Hit (combinational): fet_req high, not in flush cycle, and some way has valid and matching tag. fet_valid = hit; fet_instr = that way's word at the offset; fet_instr = 0 when no hit. Ways are mutually exclusive by construction.
- Reset (rst low at posedge):
  - All valid bits, victim pointers, counter = 0; state = IDLE.
  - mc_req = 0, mc_addr = 0.
  - Data and tag arrays are not cleared.
  - Reset mid-refill aborts the refill; mc_req is low after that edge.
- rdy low: no state, array or output-register change. The combinational hit path is still evaluated.
- FSM IDLE:
  - A miss with fet_req high latches set, tag, victim way (victim pointer of that set) and the base address {tag, idx, OFF zeros, 2'b00} word-aligned.
  - Then mc_req <= 1, mc_addr <= base, counter <= 0, go to REFILL.
- FSM REFILL:
  - On each mc_valid, write mc_data to victim line word[counter].
  - If counter < BLOCK_WORDS-1: counter+1, mc_addr+4.
  - Else: write tag, set valid unless the poison flag is set, advance the set's victim pointer modulo WAYS, mc_req <= 0, go to IDLE.
  - mc_addr increments wrap within ADDR_W.
  - The victim line's valid bit is cleared at refill start, so a stale hit on that way is impossible.
- fet_pc changes during REFILL: the refill completes for the latched line and is not aborted. Hits in other lines return normally during REFILL. A new miss waits for IDLE.
- Back-to-back misses: at least one IDLE cycle between refills. mc_req is low for at least one cycle between refills.
- flush:
  - Clears all valid bits at the edge; fet_valid is forced 0 in that cycle.
  - If in REFILL, sets poison: the refill finishes its words but is not validated. Poison clears on return to IDLE.
  - flush and a final mc_valid in the same cycle: the line stays invalid.
- Victim pointer when WAYS = 1: constant 0.

Optional Feature:
- ICACHE_FORWARD_EN defined: critical-word forward during REFILL. fet_valid = 1 and fet_instr = mc_data when all of the following hold:
  - mc_valid is high.
  - fet_pc's tag and index equal the latched ones.
  - Offset equals counter.
  - Not poisoned.
- Not defined: fet_valid only from stored hits; the first hit comes the cycle after the line is validated.

Decomposition:
- Shared const package (existing const.v style): TRUE/FALSE, ZERO, state encodings IDLE/REFILL, and derived widths OFF_W, IDX_W, TAG_W as functions of the parameters.
- One natural sub-module: icache_way, one tag/valid/data way, instantiated WAYS times. It provides a lookup port (idx, tag -> hit, word) and a write port (word write, tag write, valid set/clear, global clear).

Test Plan:
- Cold miss, WAYS=2, BLOCK_WORDS=4: fet_pc=0x100 -> mc_req rises, mc_addr sequence 0x100, 0x104, 0x108, 0x10C; supply data D0..D3 -> fet_valid with fet_instr=D0. fet_pc=0x10C then hits with D3 and no new mc_req.
- Conflict replacement, SETS=16: fill 0x100 and 0x1100 (same set, ways 0 and 1), then 0x2100 -> evicts way 0. Now 0x100 misses and 0x1100 hits.
- Flush mid-refill: assert flush after 2 of 4 words -> refill completes with mc_req low after word 4. Re-request of 0x100 misses again and refetches.
- rdy low for 3 cycles during REFILL with mc_valid held low: counter and mc_addr unchanged, refill resumes correctly.
- Reset (rst=0) during REFILL at word 2: mc_req=0 next cycle; fet_pc=0x100 misses and refill restarts at 0x100.
- Forward enabled: miss at 0x108 -> fet_valid=1 with mc_data in the cycle the third word (counter=2) arrives. Disabled -> fet_valid=1 only after the 4th word is written.
